sram_like_to_axi: RTL

SRAM_LIKE_TO_AXI -- requirements
Module: sram_like_to_axi

---
 rtl/sram_like_to_axi_pkg.sv | 29 ++
 rtl/sram_like_to_axi_wstrb_gen.sv | 12 +
 rtl/sram_like_to_axi.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sram_like_to_axi_pkg.sv
// Shared definitions for the sram-like to AXI bridge: FSM encoding and
// size-to-AXI mapping helpers.
package sram_like_to_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } bridge_state_t;

  // Size code 11 is treated as a word access.
  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    return (size == 2'b11) ? 3'd2 : {1'b0, size};
  endfunction

  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'b00:   strb = 4'b0001 << addr_lo;
      2'b01:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_like_to_axi_wstrb_gen.sv
// Write-strobe generator: pure function of access size and low address bits.
module axi_wstrb_gen
  import sram_like_to_axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  assign wstrb = size_to_wstrb(size, addr_lo);

endmodule

// File: rtl/sram_like_to_axi.sv
// Bridge from two sram-like ports (inst, data) to a single-beat AXI master,
// one outstanding transaction at a time.
module sram_like_to_axi
  import sram_like_to_axi_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_t state, state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        owner_data_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic sel_data, sel_inst, accept;
  logic aw_fire, w_fire;
  logic unused_inputs;

  assign sel_data = data_req & (DATA_FIRST | ~inst_req);
  assign sel_inst = inst_req & ~sel_data;
  assign accept   = (state == IDLE) & (sel_data | sel_inst);
  assign aw_fire  = awvalid & awready;
  assign w_fire   = wvalid & wready;

  assign unused_inputs = ^{inst_wr, inst_wdata, rlast};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_data | sel_inst)
                 state_next = (sel_data & data_wr) ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (arready) state_next = RD_DATA;
      RD_DATA: if (rvalid) state_next = IDLE;
      WR_ADDR: if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) state_next = WR_RESP;
      WR_RESP: if (bvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // addr_ok is gated by resetn so a held request cannot leak through during reset.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state)
      IDLE: begin
        inst_addr_ok = resetn & sel_inst;
        data_addr_ok = resetn & sel_data;
      end
      RD_ADDR: arvalid = 1'b1;
      RD_DATA: begin
        rready       = 1'b1;
        inst_data_ok = rvalid & ~owner_data_q;
        data_data_ok = rvalid & owner_data_q;
      end
      WR_ADDR: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
      WR_RESP: begin
        bready       = 1'b1;
        data_data_ok = bvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      wr_q         <= 1'b0;
      owner_data_q <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q       <= sel_data ? data_addr : inst_addr;
        size_q       <= sel_data ? data_size : inst_size;
        wdata_q      <= sel_data ? data_wdata : '0;
        wr_q         <= sel_data & data_wr;
        owner_data_q <= sel_data;
      end
      if (state == WR_ADDR) begin
        aw_done_q <= aw_done_q | aw_fire;
        w_done_q  <= w_done_q | w_fire;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

  axi_wstrb_gen u_wstrb_gen (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign arsize     = size_to_axsize(size_q);
  assign awsize     = size_to_axsize(size_q);
  assign wdata      = wdata_q;
  assign wlast      = 1'b1;
  assign inst_rdata = inst_data_ok ? rdata : '0;
  assign data_rdata = (data_data_ok & ~wr_q) ? rdata : '0;

endmodule
